// File: rtl/bitpack_pkg.sv
// Shared defaults, code/size types and arbiter state encoding for bitpack_arbiter.
package bitpack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SIZEW = 5;

    typedef logic [DEF_WIDTH-1:0] code_t;
    typedef logic [DEF_SIZEW-1:0] size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bitpack_arbiter_chk.sv
// Simulation checks on the requester side of bitpack_arbiter.
module bitpack_arbiter_chk #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int SIZEW = 5
) (
    input logic                       clk,
    input logic                       rst,
    input logic [NREQ-1:0]            req_rdy,
    input logic [NREQ-1:0][SIZEW-1:0] req_size
);

    for (genvar i = 0; i < NREQ; i++) begin : g_size
        // An accepted beat must never claim more bits than the packer word holds.
        a_size_legal: assert property (@(posedge clk) disable iff (rst)
            req_rdy[i] |-> (req_size[i] <= SIZEW'(WIDTH)));
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    logic [IDXW-1:0] idx;

    // Scan NREQ slots starting at the pointer and keep the first hit.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDXW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any            = 1'b1;
                grant_oh[idx]  = 1'b1;
                grant_idx      = idx;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/bitpack_arbiter.sv
// Packet-level round-robin front end for a shared code_shifter bit packer, with frame flush sequencing.
// Optional statistics outputs are enabled by defining BITPACK_ARB_STATS_EN.
module bitpack_arbiter
    import bitpack_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZEW = DEF_SIZEW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0] req_code,
    input  logic [NREQ-1:0][SIZEW-1:0] req_size,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_rdy,
    input  logic                       eof_req,
    output logic                       eof_done,
    output logic                       sh_ena,
    output logic [WIDTH-1:0]           sh_code,
    output logic [SIZEW-1:0]           sh_size,
    output logic                       sh_flush,
    input  logic                       sh_rdy
`ifdef BITPACK_ARB_STATS_EN
    ,
    output logic [31:0]                stat_bits,
    output logic [NREQ-1:0][15:0]      stat_pkts
`endif
);

    localparam int              IDXW     = $clog2(NREQ);
    localparam logic [SIZEW-1:0] SIZE_MAX = SIZEW'(WIDTH);

    arb_state_e      state;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_oh;
    logic            eof_pend;

    logic [NREQ-1:0] pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            can_take;
    logic            accept;
    logic [SIZEW-1:0] beat_size;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    bitpack_arbiter_chk #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZEW(SIZEW)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .req_rdy  (req_rdy),
        .req_size (req_size)
    );

    // Beat handshake toward the granted requester; oversize codes are clamped.
    always_comb begin
        can_take  = (state == GRANT) && (!sh_ena || sh_rdy);
        req_rdy   = can_take ? (gnt_oh & req_valid) : '0;
        accept    = |req_rdy;
        beat_size = (req_size[gnt_idx] > SIZE_MAX) ? SIZE_MAX : req_size[gnt_idx];
    end

    // Arbitration/flush FSM plus the output register feeding the packer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            gnt_oh   <= '0;
            eof_pend <= 1'b0;
            sh_ena   <= 1'b0;
            sh_code  <= '0;
            sh_size  <= '0;
            sh_flush <= 1'b0;
            eof_done <= 1'b0;
        end else begin
            eof_done <= 1'b0;
            if (eof_req) begin
                eof_pend <= 1'b1;
            end

            // Zero-size beats are consumed without reaching the packer.
            if (accept && (beat_size != '0)) begin
                sh_ena  <= 1'b1;
                sh_code <= req_code[gnt_idx];
                sh_size <= beat_size;
            end else if (sh_rdy) begin
                sh_ena <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // A same-cycle eof_req already outranks any waiting requester.
                    if (eof_pend || eof_req) begin
                        if (!sh_ena) begin
                            sh_flush <= 1'b1;
                            state    <= FLUSH;
                        end
                    end else if (pick_any) begin
                        gnt_idx <= pick_idx;
                        gnt_oh  <= pick_oh;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept && req_last[gnt_idx]) begin
                        rr_ptr <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
                        state  <= IDLE;
                    end
                end
                FLUSH: begin
                    if (sh_rdy) begin
                        sh_flush <= 1'b0;
                        eof_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    eof_pend <= eof_req;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BITPACK_ARB_STATS_EN
    // Bits handed to the packer per frame and packets completed per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bits <= '0;
            stat_pkts <= '0;
        end else begin
            if (state == DONE) begin
                stat_bits <= '0;
            end else if (sh_ena && sh_rdy) begin
                stat_bits <= stat_bits + 32'(sh_size);
            end
            if (accept && req_last[gnt_idx]) begin
                stat_pkts[gnt_idx] <= stat_pkts[gnt_idx] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bitpack_arbiter.sv
// Randomized and directed bench for bitpack_arbiter against a packet-level reference model and a packer model.
module tb_bitpack_arbiter;
    import bitpack_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = DEF_WIDTH;
    localparam int SIZEW = DEF_SIZEW;

    typedef struct packed {
        logic [WIDTH-1:0] code;
        logic [SIZEW-1:0] size;
        logic             last;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0][WIDTH-1:0] req_code = '0;
    logic [NREQ-1:0][SIZEW-1:0] req_size = '0;
    logic [NREQ-1:0]            req_last = '0;
    logic [NREQ-1:0]            req_rdy;
    logic                       eof_req = 1'b0;
    logic                       eof_done;
    logic                       sh_ena;
    logic [WIDTH-1:0]           sh_code;
    logic [SIZEW-1:0]           sh_size;
    logic                       sh_flush;
    logic                       sh_rdy = 1'b0;
`ifdef BITPACK_ARB_STATS_EN
    logic [31:0]                stat_bits;
    logic [NREQ-1:0][15:0]      stat_pkts;
`endif

    bitpack_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZEW(SIZEW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_code(req_code), .req_size(req_size), .req_last(req_last),
        .req_rdy(req_rdy),
        .eof_req(eof_req), .eof_done(eof_done),
        .sh_ena(sh_ena), .sh_code(sh_code), .sh_size(sh_size), .sh_flush(sh_flush), .sh_rdy(sh_rdy)
`ifdef BITPACK_ARB_STATS_EN
        , .stat_bits(stat_bits), .stat_pkts(stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  cmp_en = 1'b0;
    bit  eof_kick = 1'b0;
    int  rdy_mode = 0;
    beat_t rq [NREQ][$];

    // Reference model: who owns the packer, pending frame end, and what sits at the packer pins.
    int               m_owner = -1;
    int               m_ptr = 0;
    bit               m_pend = 1'b0;
    bit               m_out_v = 1'b0;
    bit               m_flush = 1'b0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_code = '0;
    logic [SIZEW-1:0] m_size = '0;

    int               rdy_cyc[$];
    int               rdy_idx[$];
    int               ena_cyc[$];
    int               xf_cyc[$];
    logic [WIDTH-1:0] xf_code[$];
    int               xf_size[$];
    int               flush_cyc[$];
    int               done_cyc[$];
    bit               pk_bits[$];
    logic [WIDTH-1:0] pk_words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] model_rdy();
        logic [NREQ-1:0] v;
        v = '0;
        if (m_owner >= 0 && (!m_out_v || sh_rdy) && req_valid[m_owner]) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int  g;
        bit  take;
        bit  was_out;
        bit  found;
        g = m_owner;
        was_out = m_out_v;
        take = (model_rdy() != '0);
        if (take && req_size[g] != '0) begin
            m_out_v = 1'b1;
            m_code  = req_code[g];
            m_size  = (req_size[g] > SIZEW'(WIDTH)) ? SIZEW'(WIDTH) : req_size[g];
        end else if (sh_rdy) begin
            m_out_v = 1'b0;
        end
        if (take) void'(rq[g].pop_front());
        if (m_done) begin
            m_done = 1'b0;
            m_pend = eof_req;
        end else if (m_flush) begin
            if (sh_rdy) begin
                m_flush = 1'b0;
                m_done  = 1'b1;
            end
        end else if (g >= 0) begin
            if (eof_req) m_pend = 1'b1;
            if (take && req_last[g]) begin
                m_ptr   = (g + 1) % NREQ;
                m_owner = -1;
            end
        end else if (m_pend || eof_req) begin
            m_pend = 1'b1;
            if (!was_out) m_flush = 1'b1;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NREQ;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_pend = 1'b0; m_out_v = 1'b0;
            m_flush = 1'b0; m_done = 1'b0; m_code = '0; m_size = '0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison plus event logs and the packer model fed by real DUT transfers.
    always @(negedge clk) begin
        logic [WIDTH-1:0] w;
        #1;
        if (cmp_en) begin
            check("req_rdy", req_rdy, model_rdy());
            check("sh_ena", sh_ena, m_out_v);
            check("sh_flush", sh_flush, m_flush);
            check("eof_done", eof_done, m_done);
            if (m_out_v) begin
                check("sh_code", sh_code, m_code);
                check("sh_size", sh_size, m_size);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_rdy[i]) begin rdy_cyc.push_back(cyc); rdy_idx.push_back(i); end
            end
            if (sh_ena) ena_cyc.push_back(cyc);
            if (eof_done) done_cyc.push_back(cyc);
            if (sh_ena && sh_rdy) begin
                xf_cyc.push_back(cyc); xf_code.push_back(sh_code); xf_size.push_back(int'(sh_size));
                for (int b = int'(sh_size) - 1; b >= 0; b--) pk_bits.push_back(sh_code[b]);
            end
            if (sh_flush && sh_rdy) begin
                flush_cyc.push_back(cyc);
                if (pk_bits.size() > 0) while (pk_bits.size() % WIDTH != 0) pk_bits.push_back(1'b0);
            end
            while (pk_bits.size() >= WIDTH) begin
                for (int b = WIDTH - 1; b >= 0; b--) w[b] = pk_bits.pop_front();
                pk_words.push_back(w);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1; req_code[i] = rq[i][0].code;
                req_size[i]  = rq[i][0].size; req_last[i] = rq[i][0].last;
            end else begin
                req_valid[i] = 1'b0; req_code[i] = '0; req_size[i] = '0; req_last[i] = 1'b0;
            end
        end
        case (rdy_mode)
            0: sh_rdy = 1'b1;
            1: sh_rdy = ($urandom_range(3) != 0);
            default: sh_rdy = 1'b0;
        endcase
        eof_req  = eof_kick;
        eof_kick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int r, input logic [WIDTH-1:0] code, input int size, input bit last);
        beat_t b;
        b.code = code; b.size = SIZEW'(size); b.last = last;
        rq[r].push_back(b);
    endtask

    task automatic clear_logs();
        rdy_cyc.delete(); rdy_idx.delete(); ena_cyc.delete(); xf_cyc.delete(); xf_code.delete();
        xf_size.delete(); flush_cyc.delete(); done_cyc.delete(); pk_bits.delete(); pk_words.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        rdy_mode = 0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    function automatic logic [63:0] qv(input int q[$], input int i);
        return (q.size() > i) ? 64'(q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] qc(input logic [WIDTH-1:0] q[$], input int i);
        return (q.size() > i) ? 64'(q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        int k;
        int r;
        int n;
        bit idle;
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        int n;
        bit idle;

        do_reset();
        cmp_en = 1'b1;
        #2;
        check("reset_sh_ena", sh_ena, 1'b0);
        check("reset_sh_flush", sh_flush, 1'b0);
        check("reset_eof_done", eof_done, 1'b0);
        check("reset_req_rdy", req_rdy, 4'b0000);
        check("reset_sh_code", sh_code, 16'h0000);

        // Two-beat packet: latency and throughput.
        push(0, 16'h0401, 11, 1'b0);
        push(0, 16'h0041, 7, 1'b1);
        tick(); k = cyc;
        ticks(8);
        check("t1_rdy_count", rdy_cyc.size(), 2);
        check("t1_rdy_c0", qv(rdy_cyc, 0), k + 1);
        check("t1_rdy_c1", qv(rdy_cyc, 1), k + 2);
        check("t1_ena_c0", qv(ena_cyc, 0), k + 2);
        check("t1_ena_c1", qv(ena_cyc, 1), k + 3);
        check("t1_code0", qc(xf_code, 0), 16'h0401);
        check("t1_code1", qc(xf_code, 1), 16'h0041);
        check("t1_size1", qv(xf_size, 1), 7);

        // Contention between requesters 0 and 2: whole packets, rotating priority.
        do_reset();
        push(0, 16'h0011, 8, 1'b0); push(0, 16'h0022, 8, 1'b1);
        push(2, 16'h0033, 8, 1'b0); push(2, 16'h0044, 8, 1'b1);
        ticks(20);
        check("t2_count", xf_code.size(), 4);
        check("t2_b0", qc(xf_code, 0), 16'h0011);
        check("t2_b1", qc(xf_code, 1), 16'h0022);
        check("t2_b2", qc(xf_code, 2), 16'h0033);
        check("t2_b3", qc(xf_code, 3), 16'h0044);

        // Packer backpressure mid-packet.
        do_reset();
        for (int b = 0; b < 4; b++) push(1, WIDTH'(16'h0101 + b), 12, b == 3);
        ticks(3);
        rdy_mode = 2; ticks(5);
        rdy_mode = 0; ticks(15);
        check("t3_rdy_count", rdy_cyc.size(), 4);
        check("t3_count", xf_code.size(), 4);
        for (int b = 0; b < 4; b++) check("t3_code", qc(xf_code, b), 16'h0101 + b);

        // End of frame requested during a packet.
        do_reset();
        for (int b = 0; b < 3; b++) push(1, WIDTH'(16'h0010 + b), 5, b == 2);
        tick(); k = cyc;
        eof_kick = 1'b1; tick();
        ticks(20);
        check("t4_count", xf_code.size(), 3);
        check("t4_last_xf", qv(xf_cyc, 2), k + 4);
        check("t4_flush", qv(flush_cyc, 0), k + 6);
        check("t4_done", qv(done_cyc, 0), k + 7);
        check("t4_done_count", done_cyc.size(), 1);

        // End of frame beats a waiting requester; zero-size last beat closes the packet.
        do_reset();
        push(3, 16'h0005, 3, 1'b0);
        push(3, 16'h0000, 0, 1'b1);
        eof_kick = 1'b1;
        tick(); k = cyc;
        ticks(20);
        check("t5_flush", qv(flush_cyc, 0), k + 1);
        check("t5_done", qv(done_cyc, 0), k + 2);
        check("t5_rdy0", qv(rdy_cyc, 0), k + 4);
        check("t5_rdy_count", rdy_cyc.size(), 2);
        check("t5_count", xf_code.size(), 1);
        check("t5_code", qc(xf_code, 0), 16'h0005);

        // End-to-end packer words.
        do_reset();
        push(0, 16'h0401, 11, 1'b0);
        push(0, 16'h0041, 7, 1'b0);
        push(0, 16'hAAAB, 16, 1'b1);
        tick();
        eof_kick = 1'b1;
        ticks(20);
        check("t6_words", pk_words.size(), 3);
        check("t6_w0", qc(pk_words, 0), 16'h8030);
        check("t6_w1", qc(pk_words, 1), 16'h6AAA);
        check("t6_w2", qc(pk_words, 2), 16'hC000);

        // Random traffic with a mid-run reset.
        do_reset();
        rdy_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                r = $urandom_range(NREQ - 1);
                if (rq[r].size() < 6) begin
                    n = $urandom_range(4, 1);
                    for (int b = 0; b < n; b++)
                        push(r, WIDTH'($urandom), $urandom_range(WIDTH), b == n - 1);
                end
            end
            if ($urandom_range(59) == 0) eof_kick = 1'b1;
            if (c == 1500) begin
                for (int i = 0; i < NREQ; i++) rq[i].delete();
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        rdy_mode = 0;
        idle = 1'b0;
        for (int c = 0; c < 400 && !idle; c++) begin
            tick();
            idle = (m_owner < 0) && !m_out_v && !m_flush && !m_done && !m_pend;
            for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) idle = 1'b0;
        end
        check("drain_done", idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
